// File: rtl/sev_seg_monitor_if.sv
// Display-side bundle for sev_seg_monitor: sampled segment/anode lines in,
// reconstructed digit state and event pulses out.
interface sev_seg_monitor_if;
  logic [6:0]      Seg;
  logic [7:0]      AN;
  logic [7:0][3:0] digits;
  logic [7:0]      digit_valid;
  logic            frame_done;
  logic            err;

  modport master (
    output Seg, AN,
    input  digits, digit_valid, frame_done, err
  );

  modport slave (
    input  Seg, AN,
    output digits, digit_valid, frame_done, err
  );
endinterface

// File: rtl/sev_seg_monitor.sv
// Reconstructs the eight hex digits shown on a multiplexed active-low seven-segment
// display. Define SEV_SEG_MONITOR_STALE_CHECK_EN to enable per-digit refresh timeouts.
module sev_seg_monitor #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 4194304
) (
  input logic              clk,
  input logic              resetn,
  sev_seg_monitor_if.slave mon
);

  typedef enum logic [1:0] {ST_WAIT, ST_EVAL, ST_HOLD} state_t;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || STALE_CYCLES < 1) begin : g_param_check
    $error("sev_seg_monitor: parameter out of range");
  end

  state_t          state_q, state_d;
  logic [6:0]      meta_seg_q, meta_seg_d, s_seg_q, s_seg_d;
  logic [7:0]      meta_an_q, meta_an_d, s_an_q, s_an_d;
  logic [7:0]      stable_cnt_q, stable_cnt_d;
  logic [7:0][3:0] digits_q, digits_d;
  logic [7:0]      digit_valid_q, digit_valid_d;
  logic [7:0]      seen_q, seen_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic [7:0]      sel;
  logic [7:0]      capture_sel;
  logic [4:0]      dec;

`ifdef SEV_SEG_MONITOR_STALE_CHECK_EN
  localparam int unsigned        STALE_W = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE   = STALE_W'(STALE_CYCLES);
  logic [7:0][STALE_W-1:0] stale_q, stale_d;
`else
  // Without the refresh timeout a valid bit only drops on reset or a bad segment pattern.
`endif

  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40: decode = {1'b1, 4'h0};
      7'h79: decode = {1'b1, 4'h1};
      7'h24: decode = {1'b1, 4'h2};
      7'h30: decode = {1'b1, 4'h3};
      7'h19: decode = {1'b1, 4'h4};
      7'h12: decode = {1'b1, 4'h5};
      7'h02: decode = {1'b1, 4'h6};
      7'h78: decode = {1'b1, 4'h7};
      7'h00: decode = {1'b1, 4'h8};
      7'h10: decode = {1'b1, 4'h9};
      7'h08: decode = {1'b1, 4'hA};
      7'h03: decode = {1'b1, 4'hB};
      7'h46: decode = {1'b1, 4'hC};
      7'h21: decode = {1'b1, 4'hD};
      7'h06: decode = {1'b1, 4'hE};
      7'h0E: decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    meta_seg_d = mon.Seg;
    meta_an_d  = mon.AN;
    s_seg_d    = meta_seg_q;
    s_an_d     = meta_an_q;
    // Looking at the pair about to enter s_seg/s_an lets EVAL land exactly
    // SETTLE_CYCLES edges after the synchronized value changes.
    if ({meta_seg_q, meta_an_q} != {s_seg_q, s_an_q}) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != SETTLE) begin
      stable_cnt_d = stable_cnt_q + 8'd1;
    end else begin
      stable_cnt_d = stable_cnt_q;
    end

    sel           = ~s_an_q;
    dec           = decode(s_seg_q);
    state_d       = state_q;
    capture_sel   = '0;
    err_d         = 1'b0;
    frame_done_d  = 1'b0;
    digits_d      = digits_q;
    digit_valid_d = digit_valid_q;
    seen_d        = seen_q;

    case (state_q)
      ST_WAIT: if (stable_cnt_d == SETTLE) state_d = ST_EVAL;
      ST_EVAL: begin
        state_d = (stable_cnt_d == '0) ? ST_WAIT : ST_HOLD;
        if (sel != '0) begin
          if (!$onehot(sel)) begin
            err_d = 1'b1;
          end else if (dec[4]) begin
            capture_sel = sel;
          end else begin
            err_d         = 1'b1;
            digit_valid_d = digit_valid_q & ~sel;
          end
        end
      end
      ST_HOLD: if (stable_cnt_d == '0) state_d = ST_WAIT;
      default: state_d = ST_WAIT;
    endcase

    for (int i = 0; i < 8; i++) begin
      if (capture_sel[i]) begin
        digits_d[i]      = dec[3:0];
        digit_valid_d[i] = 1'b1;
      end
    end
    // Re-capturing an already seen index never completes a frame on its own.
    if (capture_sel != '0) begin
      if ((seen_q | capture_sel) == 8'hFF) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_q | capture_sel;
      end
    end

`ifdef SEV_SEG_MONITOR_STALE_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      if (capture_sel[i]) begin
        stale_d[i] = '0;
      end else if (stale_q[i] != STALE) begin
        stale_d[i] = stale_q[i] + STALE_W'(1);
      end else begin
        stale_d[i] = stale_q[i];
      end
      if (!capture_sel[i] && stale_d[i] == STALE) digit_valid_d[i] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_seg_q    <= 7'h7F;
      s_seg_q       <= 7'h7F;
      meta_an_q     <= 8'hFF;
      s_an_q        <= 8'hFF;
      stable_cnt_q  <= '0;
      state_q       <= ST_WAIT;
      digits_q      <= '0;
      digit_valid_q <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      meta_seg_q    <= meta_seg_d;
      s_seg_q       <= s_seg_d;
      meta_an_q     <= meta_an_d;
      s_an_q        <= s_an_d;
      stable_cnt_q  <= stable_cnt_d;
      state_q       <= state_d;
      digits_q      <= digits_d;
      digit_valid_q <= digit_valid_d;
      seen_q        <= seen_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

`ifdef SEV_SEG_MONITOR_STALE_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stale_q <= '0;
    else         stale_q <= stale_d;
  end
`endif

  assign mon.digits      = digits_q;
  assign mon.digit_valid = digit_valid_q;
  assign mon.frame_done  = frame_done_q;
  assign mon.err         = err_q;

endmodule

// File: tb/tb_sev_seg_monitor.sv
// Randomized bench for sev_seg_monitor: each stable pin pattern is judged by a
// digit-level model (table lookup, seen set, capture timestamps).
module tb_sev_seg_monitor;

  localparam int SETTLE = 4;
  localparam int STALE  = 100;
  localparam int LAT    = SETTLE + 3;
`ifdef SEV_SEG_MONITOR_STALE_CHECK_EN
  localparam bit STALE_EN = 1'b1;
`else
  localparam bit STALE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;

  sev_seg_monitor_if bus();

  sev_seg_monitor #(
    .SETTLE_CYCLES(SETTLE),
    .STALE_CYCLES (STALE)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .mon   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  m_digits [8];
  logic [7:0]  m_valid;
  logic [7:0]  m_seen;
  longint      cap_cyc [8];
  logic [14:0] cur_pat;

  int     checks;
  int     failures;
  longint cyc;
  int     win_tick;
  int     err_pulses, fd_pulses, err_at, fd_at;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    win_tick++;
    #1;
    if (bus.err === 1'b1) begin err_pulses++; err_at = win_tick; end
    if (bus.frame_done === 1'b1) begin fd_pulses++; fd_at = win_tick; end
  endtask

  task automatic clearWindow();
    win_tick = 0; err_pulses = 0; fd_pulses = 0; err_at = -1; fd_at = -1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin m_digits[i] = 4'h0; cap_cyc[i] = 0; end
    m_valid = '0;
    m_seen  = '0;
    cur_pat = {8'hFF, 7'h7F};
  endtask

  task automatic modelApply(input logic [7:0] an, input logic [6:0] seg, output bit e_err, output bit e_fd);
    int lows, idx, val;
    e_err = 1'b0;
    e_fd  = 1'b0;
    if ({an, seg} == cur_pat) return;
    cur_pat = {an, seg};
    lows = 0; idx = 0; val = -1;
    for (int i = 0; i < 8; i++) if (!an[i]) begin lows++; idx = i; end
    for (int k = 0; k < 16; k++) if (seg_code[k] == seg) val = k;
    if (lows > 1) begin
      e_err = 1'b1;
    end else if (lows == 1) begin
      if (val >= 0) begin
        m_digits[idx] = 4'(val);
        m_valid[idx]  = 1'b1;
        cap_cyc[idx]  = cyc + LAT;
        m_seen[idx]   = 1'b1;
        if (m_seen == 8'hFF) begin e_fd = 1'b1; m_seen = '0; end
      end else begin
        e_err        = 1'b1;
        m_valid[idx] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] expDigits();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[i*4 +: 4] = m_digits[i];
    return v;
  endfunction

  function automatic logic [7:0] expValid();
    logic [7:0] v;
    v = m_valid;
    if (STALE_EN) for (int i = 0; i < 8; i++) if (cyc - cap_cyc[i] >= STALE) v[i] = 1'b0;
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg, input int hold);
    bit e_err, e_fd;
    bus.AN  = an;
    bus.Seg = seg;
    clearWindow();
    modelApply(an, seg, e_err, e_fd);
    repeat (hold) tick();
    checkOutput("err_pulses", err_pulses, 32'(e_err));
    checkOutput("frame_pulses", fd_pulses, 32'(e_fd));
    if (e_err) checkOutput("err_latency", err_at, LAT);
    if (e_fd) checkOutput("frame_latency", fd_at, LAT);
    checkOutput("digits", bus.digits, expDigits());
    checkOutput("digit_valid", bus.digit_valid, expValid());
  endtask

  task automatic glitchPins(input logic [7:0] an, input logic [6:0] seg, input int n);
    bus.AN  = an;
    bus.Seg = seg;
    cur_pat = {an, seg};
    repeat (n) tick();
  endtask

  task automatic randomStep();
    logic [7:0] an;
    logic [6:0] seg, gseg;
    int a, b, r, k;
    r = $urandom_range(0, 9);
    a = $urandom_range(0, 7);
    if (r == 0) begin
      an = 8'hFF;
    end else if (r <= 2) begin
      b  = (a + $urandom_range(1, 7)) % 8;
      an = 8'($urandom) & ~(8'h01 << a) & ~(8'h01 << b);
    end else begin
      an = ~(8'h01 << a);
    end
    k = $urandom_range(0, 15);
    if ($urandom_range(0, 4) != 0) seg = seg_code[k];
    else seg = 7'($urandom);
    if ($urandom_range(0, 9) == 0) begin an = cur_pat[14:7]; seg = cur_pat[6:0]; end
    if ($urandom_range(0, 4) == 0) begin
      do gseg = 7'($urandom); while (gseg == seg);
      glitchPins(an, gseg, $urandom_range(1, 2));
    end
    applyStimulus(an, seg, $urandom_range(LAT + 2, LAT + 9));
  endtask

  initial begin
    logic [7:0] v;
    bit e_err, e_fd;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    clearWindow();
    resetn  = 1'b0;
    bus.AN  = 8'hFF;
    bus.Seg = 7'h7F;
    modelReset();
    repeat (3) tick();
    checkOutput("rst_digits", bus.digits, 32'h0);
    checkOutput("rst_valid", bus.digit_valid, 8'h00);
    checkOutput("rst_err", bus.err, 1'b0);
    checkOutput("rst_frame", bus.frame_done, 1'b0);
    resetn = 1'b1;
    repeat (10) tick();

    // First capture: nothing visible one edge early, visible exactly LAT edges in.
    bus.AN  = 8'hFE;
    bus.Seg = 7'h40;
    clearWindow();
    modelApply(8'hFE, 7'h40, e_err, e_fd);
    repeat (LAT - 1) tick();
    checkOutput("lat_early_valid", bus.digit_valid, 8'h00);
    tick();
    checkOutput("lat_valid", bus.digit_valid, 8'h01);
    checkOutput("lat_digit0", bus.digits[0], 4'h0);
    checkOutput("lat_err", bus.err, 1'b0);
    repeat (5) tick();

    for (int d = 0; d < 8; d++) applyStimulus(~(8'h01 << d), seg_code[d+1], 20);
    checkOutput("sweep_digits", bus.digits, 32'h87654321);

    clearWindow();
    for (int t = 0; t < 6; t++) glitchPins(8'hFE, (t % 2 == 0) ? 7'h79 : 7'h40, 2);
    checkOutput("toggle_err", err_pulses, 0);
    checkOutput("toggle_digits", bus.digits, expDigits());
    applyStimulus(8'hFE, 7'h79, 20);
    checkOutput("toggle_digit0", bus.digits[0], 4'h1);

    applyStimulus(8'hFC, 7'h40, 20);
    applyStimulus(8'hFB, 7'h7F, 20);
    checkOutput("bad_seg_valid2", bus.digit_valid[2], 1'b0);

    bus.AN  = 8'hF7;
    bus.Seg = 7'h00;
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    checkOutput("midrst_digits", bus.digits, 32'h0);
    checkOutput("midrst_valid", bus.digit_valid, 8'h00);
    checkOutput("midrst_err", bus.err, 1'b0);
    checkOutput("midrst_frame", bus.frame_done, 1'b0);
    tick();
    resetn = 1'b1;
    modelReset();
    applyStimulus(8'hF7, 7'h00, 20);
    checkOutput("midrst_digit3", bus.digits[3], 4'h8);

    applyStimulus(8'hDF, seg_code[$urandom_range(0, 15)], 12);
    applyStimulus(8'hFF, 7'h7F, STALE + 10);
    v = expValid();
    checkOutput("stale_valid5", bus.digit_valid[5], v[5]);
    checkOutput("stale_digit5", bus.digits[5], m_digits[5]);

    for (int n = 0; n < 150; n++) randomStep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sev_seg_monitor.md
# sev_seg_monitor

- Receive-side counterpart of the multiplexed seven-segment driver.
- Samples the time-multiplexed segment lines and anode strobes, and reconstructs the eight 4-bit hex digits being displayed.
- Flags malformed strobes or segment patterns.
- Sits on the board-test/loopback path, so a bench or on-chip checker can read back what the display shows.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: consecutive identical synchronized samples required before a pattern is accepted (legal range 1..255).
- STALE_CYCLES, default 4194304: refresh timeout per digit; used only with the stale-check macro.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- Seg  input  7  segment lines, active-low, bit6..bit0 = g,f,e,d,c,b,a.
- AN  input  8  anode strobes, active-low; exactly one low selects digit index 0..7.
- digits  output  [3:0] x [7:0]  last decoded value per digit index.
- digit_valid  output  8  bit i set once digit i has been captured legally.
- frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
- err  output  1  one-cycle pulse on an illegal stable pattern.

## Operation
- Input conditioning:
  - Seg and AN pass through a 2-flop synchronizer, giving s_seg and s_an.
  - A prev register holds the previous synchronized pair.
  - stable_cnt clears to 0 when {s_seg,s_an} differs from prev; otherwise it increments, saturating at SETTLE_CYCLES.
- State machine:
  - WAIT: pattern changing. When stable_cnt reaches SETTLE_CYCLES, go to EVAL.
  - EVAL (1 cycle): classify the pattern and act on it, then go to HOLD.
  - HOLD: stay until stable_cnt clears (any input change), then go to WAIT.
  - Each stable pattern is therefore evaluated exactly once.
- EVAL classification, in priority order:
  - AN = 8'hFF (blanking): no action, no error.
  - AN has more than one bit low: err pulse; nothing stored.
  - AN one-hot-low at index i, Seg in the decode table: digits[i] <= value; digit_valid[i] <= 1; seen[i] <= 1.
  - AN one-hot-low at index i, Seg not in the table: err pulse; digit_valid[i] <= 0; digits[i] unchanged.
- Decode table (Seg hex → value):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
- Frame tracking:
  - An internal 8-bit seen vector records captures.
  - When a capture makes seen == 8'hFF, frame_done pulses in the same cycle the output update becomes visible, and seen clears to 0.
  - A re-capture of an index already in seen is legal and updates the value; it does not advance the frame.

## Timing
- Reset (asynchronous, while resetn = 0):
  - digits all 0, digit_valid = 0, frame_done = 0, err = 0.
  - seen = 0, stable_cnt = 0, state = WAIT.
  - Synchronizer flops reset to Seg = 7'h7F, AN = 8'hFF (blank).
- Latency:
  - Reference point: first clk edge sampling a new stable pin value.
  - That value reaches s_an/s_seg after 2 edges.
  - EVAL occurs SETTLE_CYCLES edges later.
  - Outputs (digits, digit_valid, frame_done, err) update on the following edge.
  - Total: SETTLE_CYCLES + 3 edges.
- Glitches: a change shorter than SETTLE_CYCLES synchronized samples is never evaluated and causes no err.
- Same pattern stable indefinitely: exactly one EVAL; no repeated err or capture.
- frame_done and err never assert in the same cycle, since one EVAL produces at most one outcome.
- Reset asserted mid-settle or mid-EVAL: state discarded immediately; no pulse is emitted after reset deasserts until a new stable pattern is seen.

## Configuration
- Macro: SEV_SEG_MONITOR_STALE_CHECK_EN.
- Defined:
  - Each digit has a counter that restarts on every legal capture of that digit.
  - When a counter reaches STALE_CYCLES, that digit_valid bit clears and the counter holds.
  - digits[i] is retained.
- Undefined: no counters; digit_valid bits clear only on reset or an illegal-segment capture.

## Test plan
- Reset, then drive AN=FE, Seg=40 stable: exactly 7 cycles later (SETTLE_CYCLES=4), digits[0]=0, digit_valid=8'h01, err=0.
- Cycle AN through FE..7F with Seg patterns for 1,2,…,8, each held 20 cycles: digits = 1..8, digit_valid = FF, one frame_done pulse on the digit-7 capture, seen restarts.
- AN=FE stable with Seg toggling 40↔79 every 2 cycles: no capture and no err; then Seg held at 79: digits[0]=1.
- AN=FC (two lows) stable: one err pulse, digits unchanged. AN=FB with Seg=7F: err pulse, digit_valid[2]=0.
- Assert resetn low for 1 cycle mid-settle of AN=F7/Seg=00: all outputs 0; after release, the held pattern is captured once as digits[3]=8.
- With SEV_SEG_MONITOR_STALE_CHECK_EN and STALE_CYCLES=100: capture digit 5, then hold AN=FF for 100 cycles; digit_valid[5] clears, digits[5] retained.
